zstr_upsize: RTL and testbench

//  Stream width up-converter on zbus stream (vld/bus/ack) handshake, single clock domain.

---
 rtl/zstr_upsize.sv | 103 ++++++++++
 tb/tb_zstr_upsize.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/zstr_upsize.sv
// zstr_upsize: zbus stream width up-converter (BW -> N*BW), single clock.
// Packs N consecutive input words into one output word, first word in LSBs.
// Output register is separate from the N-1 word accumulator, so a full
// output word can be held while the next word is being gathered.
// Optional macro ZSTR_UPSIZE_LAST_EN adds packet-last handling
// (zi_lst / zo_cnt / zo_lst): a word flagged last closes a partial output word.
module zstr_upsize #(
   parameter int BW  = 8,
   parameter int N   = 4,
   parameter int CNL = $clog2(N+1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                zi_vld,
   input  logic [BW-1:0]       zi_bus,
   output logic                zi_ack,
`ifdef ZSTR_UPSIZE_LAST_EN
   input  logic                zi_lst,
   output logic [CNL-1:0]      zo_cnt,
   output logic                zo_lst,
`endif
   output logic                zo_vld,
   output logic [N*BW-1:0]     zo_bus,
   input  logic                zo_ack
);

   // N=1 has no accumulator slots; keep one dummy slot so the array is legal.
   localparam int             AW      = (N > 1) ? N-1 : 1;
   localparam logic [CNL-1:0] CNT_MAX = CNL'(N-1);

   logic [CNL-1:0]       cnt;
   logic [AW-1:0][BW-1:0] acc;
   logic                 cmpl;
   logic                 zi_trn;
   logic                 zo_trn;
   logic [N*BW-1:0]      pack;

   // Completing word: fills the last slot (or closes a packet when enabled).
`ifdef ZSTR_UPSIZE_LAST_EN
   always_comb cmpl = (cnt == CNT_MAX) | (zi_vld & zi_lst);
`else
   always_comb cmpl = (cnt == CNT_MAX);
`endif

   // Only a completing word can stall: it needs the output register free.
   assign zi_ack = !cmpl | !zo_vld | zo_ack;
   assign zi_trn = zi_vld & zi_ack;
   assign zo_trn = zo_vld & zo_ack;

   // Assemble the outgoing word: stored slots below cnt, the live word at
   // slot cnt, zeros above it (partial words leave the upper slots clear).
   always_comb begin
      pack = '0;
      for (int i = 0; i < AW; i++)
         if (CNL'(i) < cnt) pack[i*BW +: BW] = acc[i];
      for (int i = 0; i < N; i++)
         if (CNL'(i) == cnt) pack[i*BW +: BW] = zi_bus;
   end

   // Store non-completing words into the slot selected by the fill counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (zi_trn && !cmpl) begin
         for (int i = 0; i < AW; i++)
            if (CNL'(i) == cnt) acc[i] <= zi_bus;
      end
   end

   // Fill counter: advances per accepted word, wraps only on completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         cnt <= '0;
      else if (zi_trn) cnt <= cmpl ? '0 : cnt + CNL'(1);
   end

   // Output register: load on completion (even while draining, so no
   // bubble), clear valid when drained with nothing new arriving.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zo_vld <= 1'b0;
         zo_bus <= '0;
      end else if (zi_trn && cmpl) begin
         zo_vld <= 1'b1;
         zo_bus <= pack;
      end else if (zo_trn) begin
         zo_vld <= 1'b0;
      end
   end

`ifdef ZSTR_UPSIZE_LAST_EN
   // Side-band travelling with zo_bus: word count and packet-last flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zo_cnt <= '0;
         zo_lst <= 1'b0;
      end else if (zi_trn && cmpl) begin
         zo_cnt <= cnt + CNL'(1);
         zo_lst <= zi_lst;
      end
   end
`endif

endmodule

// File: tb/tb_zstr_upsize.sv
// Bench for zstr_upsize: directed scenarios plus randomized traffic, all
// checked against a queue-based packing model (N=4) and a one-deep
// register model for a second N=1 instance.
module tb_zstr_upsize;
   localparam int BW = 8;
   localparam int N  = 4;

   logic          clk = 0;
   logic          rst;
   logic          zi_vld;
   logic [7:0]    zi_bus;
   logic          zi_ack;
   logic          zo_vld;
   logic [31:0]   zo_bus;
   logic          zo_ack;
   logic          zi_lst;
   logic [2:0]    zo_cnt;
   logic          zo_lst;

   logic          s_vld, s_ack, s_ovld, s_oack, s_lst, s_olst;
   logic [7:0]    s_bus, s_obus;
   logic [0:0]    s_ocnt;

   always #5 clk = ~clk;

   zstr_upsize #(.BW(BW), .N(N)) dut (
      .clk(clk), .rst(rst), .zi_vld(zi_vld), .zi_bus(zi_bus), .zi_ack(zi_ack),
`ifdef ZSTR_UPSIZE_LAST_EN
      .zi_lst(zi_lst), .zo_cnt(zo_cnt), .zo_lst(zo_lst),
`endif
      .zo_vld(zo_vld), .zo_bus(zo_bus), .zo_ack(zo_ack));

   zstr_upsize #(.BW(BW), .N(1)) dut1 (
      .clk(clk), .rst(rst), .zi_vld(s_vld), .zi_bus(s_bus), .zi_ack(s_ack),
`ifdef ZSTR_UPSIZE_LAST_EN
      .zi_lst(s_lst), .zo_cnt(s_ocnt), .zo_lst(s_olst),
`endif
      .zo_vld(s_ovld), .zo_bus(s_obus), .zo_ack(s_oack));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: words gathered for the current output, and produced
   // output words not yet consumed.
   typedef struct { logic [31:0] bus; int cnt; logic lst; } ow_t;
   logic [7:0]  grp[$];
   ow_t         outq[$];
   logic [31:0] last_bus;
   int          last_cnt;
   logic        last_lst;
   int          n_out;
   int          n_acklo;

`ifdef ZSTR_UPSIZE_LAST_EN
   localparam bit LAST = 1'b1;
`else
   localparam bit LAST = 1'b0;
`endif

   task automatic model_clear();
      grp.delete();
      outq.delete();
      last_bus = '0;
      last_cnt = 0;
      last_lst = 1'b0;
   endtask

   // One cycle on the N=4 instance: drive, check against model, advance model.
   task automatic step(input logic v, input logic [7:0] w, input logic l, input logic oa);
      logic exp_vld, exp_ack, cmpl;
      ow_t  o;
      @(negedge clk);
      zi_vld = v; zi_bus = w; zi_lst = l; zo_ack = oa;
      #1;
      exp_vld = (outq.size() > 0);
      cmpl    = (grp.size() == N-1) || (LAST && v && l);
      exp_ack = !cmpl || !exp_vld || oa;
      chk("zi_ack", 64'(zi_ack), 64'(exp_ack));
      chk("zo_vld", 64'(zo_vld), 64'(exp_vld));
      chk("zo_bus", 64'(zo_bus), 64'(last_bus));
`ifdef ZSTR_UPSIZE_LAST_EN
      chk("zo_cnt", 64'(zo_cnt), 64'(last_cnt));
      chk("zo_lst", 64'(zo_lst), 64'(last_lst));
`endif
      if (!zi_ack) n_acklo++;
      @(posedge clk);
      if (exp_vld && oa) begin
         void'(outq.pop_front());
         n_out++;
      end
      if (v && exp_ack) begin
         grp.push_back(w);
         if (grp.size() == N || (LAST && l)) begin
            o.bus = '0;
            foreach (grp[i]) o.bus[i*8 +: 8] = grp[i];
            o.cnt = grp.size();
            o.lst = LAST && l;
            outq.push_back(o);
            last_bus = o.bus; last_cnt = o.cnt; last_lst = o.lst;
            grp.delete();
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; zi_vld = 1'b0; s_vld = 1'b0;
      model_clear();
      #1;
      chk("rst_zo_vld", 64'(zo_vld), 64'(0));
      chk("rst_zo_bus", 64'(zo_bus), 64'(0));
      chk("rst_s_ovld", 64'(s_ovld), 64'(0));
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] w;
      logic       pend;
      logic [7:0] held;
      logic [7:0] inq[$];
      logic       v, oa;

      rst = 1'b1; zi_vld = 0; zi_bus = 0; zi_lst = 0; zo_ack = 0;
      s_vld = 0; s_bus = 0; s_lst = 0; s_oack = 0;
      model_clear();
      #2;
      chk("reset_zo_vld", 64'(zo_vld), 64'(0));
      chk("reset_zo_bus", 64'(zo_bus), 64'(0));
      chk("reset_zi_ack", 64'(zi_ack), 64'(1));
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // 1: four words packed, valid right after the fourth accept
      step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1);
      #1 chk("t1_not_yet", 64'(zo_vld), 64'(0));
      step(1, 8'h44, 0, 1);
      #1 chk("t1_vld", 64'(zo_vld), 64'(1));
      chk("t1_bus", 64'(zo_bus), 64'h44332211);
      step(0, 8'h00, 0, 1);

      // 2: consumer stalled, second word blocks on its completing input
      for (int i = 1; i <= 7; i++) step(1, 8'(i), 0, 0);
      @(negedge clk);
      zi_vld = 1; zi_bus = 8'h08; zo_ack = 0;
      #1;
      chk("t2_ack_lo", 64'(zi_ack), 64'(0));
      chk("t2_held", 64'(zo_bus), 64'h04030201);
      step(1, 8'h08, 0, 1);
      #1 chk("t2_next", 64'(zo_bus), 64'h08070605);
      chk("t2_next_vld", 64'(zo_vld), 64'(1));
      step(0, 8'h00, 0, 1);

      // 3: continuous flow, 40 words -> 10 outputs, never stalled
      n_out = 0; n_acklo = 0;
      for (int i = 0; i < 40; i++) step(1, 8'($urandom), 0, 1);
      step(0, 8'h00, 0, 1);
      chk("t3_outs", 64'(n_out), 64'(10));
      chk("t3_acklo", 64'(n_acklo), 64'(0));

      // 4: reset mid-fill discards partial words
      step(1, 8'hA1, 0, 1); step(1, 8'hA2, 0, 1);
      do_reset();
      step(1, 8'hB1, 0, 1); step(1, 8'hB2, 0, 1); step(1, 8'hB3, 0, 1); step(1, 8'hB4, 0, 1);
      #1 chk("t4_bus", 64'(zo_bus), 64'hB4B3B2B1);
      chk("t4_vld", 64'(zo_vld), 64'(1));
      step(0, 8'h00, 0, 1);

`ifdef ZSTR_UPSIZE_LAST_EN
      // 5: packet-last closes a partial word
      step(1, 8'hAA, 0, 1); step(1, 8'hBB, 1, 1);
      #1 chk("t5_bus", 64'(zo_bus), 64'h0000BBAA);
      chk("t5_cnt", 64'(zo_cnt), 64'(2));
      chk("t5_lst", 64'(zo_lst), 64'(1));
      for (int i = 0; i < 4; i++) step(1, 8'(i + 1), 0, 1);
      #1 chk("t5_full_cnt", 64'(zo_cnt), 64'(4));
      chk("t5_full_lst", 64'(zo_lst), 64'(0));
      step(0, 8'h00, 0, 1);
`endif

      // Random traffic on the N=4 instance
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 3) != 0, 8'($urandom),
              $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1);

      // 6: N=1 instance behaves as a register slice
      pend = 0; held = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         v = ($urandom_range(0, 2) != 0);
         oa = ($urandom_range(0, 1) == 1);
         s_vld = v; s_bus = 8'($urandom); s_oack = oa;
         #1;
         chk("n1_ack", 64'(s_ack), 64'(!pend || oa));
         chk("n1_vld", 64'(s_ovld), 64'(pend));
         chk("n1_bus", 64'(s_obus), 64'(held));
         if (pend && oa && inq.size() > 0) chk("n1_order", 64'(s_obus), 64'(inq.pop_front()));
         w = s_bus;
         @(posedge clk);
         if (pend && oa) pend = 0;
         if (v && (!pend || oa)) begin
            pend = 1; held = w; inq.push_back(w);
         end
      end

      $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
      $finish;
   end
endmodule
